window_stream_3x3: RTL and testbench
====================================

Name: window_stream_3x3

Overview:
- Parametrised successor to the team's BRAM-fed 3x3 window controller.
- Reads a stored IMG_HEIGHT x IMG_WIDTH frame from BRAM exactly once, in raster order.
- Keeps the two previous image rows in internal line buffers and emits every fully-interior 3x3 window over a valid/ready handshake.
- Sits between the frame BRAM and the convolution/filter datapath.
- Sustains one window per cycle when downstream is always ready, and stalls cleanly under backpressure.

Parameters:
- IMG_WIDTH, 130, pixels per row; must be at least 3.
- IMG_HEIGHT, 130, rows per frame; must be at least 3.
- DATA_W, 8, bits per pixel.
- ADDR_W, 15, BRAM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- COORD_W, 8, width of the row/column tags; must hold IMG_HEIGHT-1 and IMG_WIDTH-1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: frame is stored in BRAM, begin streaming.
- rd_en  out  1  BRAM read strobe.
- rd_addr  out  ADDR_W  BRAM read address.
- rd_data  in  DATA_W  BRAM read data; valid exactly 1 cycle after the rd_en cycle.
- win_data  out  9*DATA_W  window; element k=3*wr+wc sits at bits [k*DATA_W +: DATA_W]; wr/wc = 0 is top/left.
- win_valid  out  1  win_data, win_row and win_col are valid.
- win_ready  in  1  downstream accepts the window.
- win_row  out  COORD_W  image row of the window centre.
- win_col  out  COORD_W  image column of the window centre.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset: every output is 0 (rd_en, rd_addr, win_data, win_valid, win_row, win_col, busy, frame_done); FSM to IDLE; pixel counters, skid register and in-flight flag cleared. Line-buffer contents need not be cleared.
- Reset asserted mid-frame aborts immediately. No frame_done is produced. The next frame needs a new start.
- FSM: IDLE -> RUN on start; RUN -> DRAIN once the read of the last pixel (address W*H-1) is issued; DRAIN -> DONE once the last window is accepted; DONE -> IDLE after one cycle, during which frame_done=1.
- start is ignored outside IDLE.
- busy=1 in RUN and DRAIN.
- Reads: rd_addr steps 0,1,...,W*H-1, incrementing only on cycles with rd_en=1. Each address is read exactly once per frame.
- rd_en=1 only in RUN, and only when the skid register is empty and the output is not stalled (stalled means win_valid && !win_ready).
- Skid register: one entry. A pixel returning while the output is stalled is parked there. It is consumed before any new read is issued.
- Pixel processing (pixel at row r, column c):
  - Shift the column from line buffer 1, line buffer 0 and the new pixel into the 3x3 shift window.
  - Write line buffer 0's old value at column c into line buffer 1.
  - Write the pixel into line buffer 0 at column c.
- A window is emitted only when r>=2 and c>=2. win_row=r-1, win_col=c-1.
- Columns 0 and 1 of each row only refill the window. Window columns from the previous row must never appear in an emitted window.
- Output register: loads on the cycle after the pixel arrives. It holds all fields stable while win_valid && !win_ready. It may reload in the same cycle it is accepted.
- Latency: with win_ready held at 1, the first window is valid 2 cycles after the rd_en cycle of pixel (2,2).
- Throughput: 1 pixel/cycle in steady state. Window count per frame = (H-2)*(W-2).
- Arithmetic: address and coordinate counters are unsigned and wrap to 0 only between frames. No pixel arithmetic is done in this block.
- Simultaneous events: start together with reset -> reset wins. win_ready while win_valid=0 -> ignored.

Test Plan:
- W=H=4, pixel value = 4r+c, win_ready=1 -> exactly 4 windows.
  - First window {0,1,2,4,5,6,8,9,10} at (1,1).
  - Last window {5,6,7,9,10,11,13,14,15} at (2,2).
  - frame_done pulses once; rd_addr covers 0..15 exactly once.
- Default 130x130, pixel = (r+c) mod 256, win_ready=1 -> 16384 windows, each matching the reference model. After the first window, windows arrive on consecutive cycles except across row boundaries.
- 130x130 with random 30% win_ready=0 -> same 16384 windows in the same order. Outputs stay stable during every stall; no pixel is lost or duplicated.
- start pulsed during RUN -> ignored; only one frame_done; window count unchanged.
- reset asserted at window 500 -> every output is 0 on the next cycle. A new start then produces the full 16384 correct windows with no stale line-buffer data.
- Row seam check on W=5, H=3, pixel = 10r+c -> windows only at (1,1), (1,2), (1,3). No window ever mixes columns 3/4 of one row with columns 0/1 of the next.

Source files
------------

// File: rtl/window_stream_3x3.sv
// Streams a stored frame out of BRAM once, in raster order, and emits every interior
// 3x3 window over a valid/ready port with a one-entry skid register for backpressure.
module window_stream_3x3 #(
  parameter int IMG_WIDTH  = 130,
  parameter int IMG_HEIGHT = 130,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 15,
  parameter int COORD_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [9*DATA_W-1:0]   win_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [COORD_W-1:0]    win_row,
  output logic [COORD_W-1:0]    win_col,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int IDX_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR    = ADDR_W'(NPIX - 1);
  localparam logic [COORD_W-1:0] LAST_COL     = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW     = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] LAST_WIN_COL = COORD_W'(IMG_WIDTH - 2);
  localparam logic [COORD_W-1:0] LAST_WIN_ROW = COORD_W'(IMG_HEIGHT - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic                  r_inflight;
  logic                  r_skid_valid;
  logic [DATA_W-1:0]     r_skid;
  logic [COORD_W-1:0]    r_pc;
  logic [COORD_W-1:0]    r_pr;
  logic [3*DATA_W-1:0]   r_col0;
  logic [3*DATA_W-1:0]   r_col1;
  logic [9*DATA_W-1:0]   r_win_data;
  logic                  r_win_valid;
  logic [COORD_W-1:0]    r_win_row;
  logic [COORD_W-1:0]    r_win_col;
  logic [DATA_W-1:0]     r_lb0 [IMG_WIDTH];
  logic [DATA_W-1:0]     r_lb1 [IMG_WIDTH];

  logic                  w_stall;
  logic                  w_rd;
  logic                  w_proc;
  logic                  w_emit;
  logic                  w_last_acc;
  logic [DATA_W-1:0]     w_pix;
  logic [IDX_W-1:0]      w_idx;
  logic [3*DATA_W-1:0]   w_newcol;
  logic [9*DATA_W-1:0]   w_win;

  // Handshake: a window transfers on every cycle with win_valid && win_ready; while
  // win_valid && !win_ready all output fields hold, and win_ready alone is ignored.
  assign w_stall    = r_win_valid && !win_ready;
  assign w_rd       = (r_state == S_RUN) && !r_skid_valid && !w_stall;
  assign w_proc     = (r_skid_valid || r_inflight) && !w_stall;
  assign w_pix      = r_skid_valid ? r_skid : rd_data;
  assign w_idx      = r_pc[IDX_W-1:0];
  assign w_newcol   = {w_pix, r_lb0[w_idx], r_lb1[w_idx]};
  assign w_emit     = w_proc && (r_pc >= COORD_W'(2)) && (r_pr >= COORD_W'(2));
  assign w_last_acc = r_win_valid && win_ready &&
                      (r_win_row == LAST_WIN_ROW) && (r_win_col == LAST_WIN_COL);

  always_comb begin
    w_win = '0;
    for (int wr = 0; wr < 3; wr++) begin
      w_win[(3*wr+0)*DATA_W +: DATA_W] = r_col0[wr*DATA_W +: DATA_W];
      w_win[(3*wr+1)*DATA_W +: DATA_W] = r_col1[wr*DATA_W +: DATA_W];
      w_win[(3*wr+2)*DATA_W +: DATA_W] = w_newcol[wr*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_rd && (r_rd_addr == LAST_ADDR)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_acc) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rd_addr    <= '0;
      r_inflight   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_pc         <= '0;
      r_pr         <= '0;
      r_col0       <= '0;
      r_col1       <= '0;
      r_win_data   <= '0;
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd;
      if ((r_state == S_IDLE) && start) begin
        r_rd_addr <= '0;
        r_pc      <= '0;
        r_pr      <= '0;
      end
      if (w_rd) r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);
      // A pixel landing while the output is stalled waits in the skid register.
      if (r_inflight && w_stall) begin
        r_skid       <= rd_data;
        r_skid_valid <= 1'b1;
      end else if (w_proc) begin
        r_skid_valid <= 1'b0;
      end
      if (w_proc) begin
        r_col0 <= r_col1;
        r_col1 <= w_newcol;
        if (r_pc == LAST_COL) begin
          r_pc <= '0;
          r_pr <= (r_pr == LAST_ROW) ? '0 : r_pr + COORD_W'(1);
        end else begin
          r_pc <= r_pc + COORD_W'(1);
        end
      end
      if (!w_stall) begin
        r_win_valid <= w_emit;
        if (w_emit) begin
          r_win_data <= w_win;
          r_win_row  <= r_pr - COORD_W'(1);
          r_win_col  <= r_pc - COORD_W'(1);
        end
      end
    end
  end

  // Line buffers carry no reset: rows 0 and 1 of each frame overwrite them before use.
  always_ff @(posedge clk) begin
    if (w_proc) begin
      r_lb1[w_idx] <= r_lb0[w_idx];
      r_lb0[w_idx] <= w_pix;
    end
  end

  assign rd_en      = w_rd;
  assign rd_addr    = r_rd_addr;
  assign win_data   = r_win_data;
  assign win_valid  = r_win_valid;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign frame_done = (r_state == S_DONE);

endmodule

// File: tb/tb_window_stream_3x3.sv
// Bench for window_stream_3x3: a 130x130 instance checked against a frame-level window
// model, plus 4x4 and 5x3 instances checked against hand-computed windows.
module tb_window_stream_3x3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [87:0] pk9(input int row, input int col,
      input int b0, input int b1, input int b2, input int b3, input int b4,
      input int b5, input int b6, input int b7, input int b8);
    logic [71:0] d;
    d = {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    return {8'(row), 8'(col), d};
  endfunction

  function automatic logic [7:0] pixf(input int sel, input int r, input int c);
    return (sel == 0) ? 8'((r + c) % 256) : 8'((3 * r + 7 * c) % 256);
  endfunction

  // ---------------- 130x130 instance ----------------
  logic        b_start = 1'b0, b_ready = 1'b1, b_rand = 1'b0, b_full = 1'b0;
  logic        b_rd_en, b_win_valid, b_busy, b_frame_done;
  logic [14:0] b_rd_addr;
  logic [7:0]  b_rd_data = '0, b_win_row, b_win_col;
  logic [71:0] b_win_data;
  int          b_sel = 0;

  window_stream_3x3 #(.IMG_WIDTH(130), .IMG_HEIGHT(130)) u_big (
    .clk(clk), .reset(reset), .start(b_start), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .win_data(b_win_data), .win_valid(b_win_valid),
    .win_ready(b_ready), .win_row(b_win_row), .win_col(b_win_col), .busy(b_busy),
    .frame_done(b_frame_done));

  always @(posedge clk)
    if (b_rd_en) b_rd_data <= pixf(b_sel, int'(b_rd_addr) / 130, int'(b_rd_addr) % 130);

  logic [87:0] exp_q[$];
  logic [87:0] b_hold;
  logic        b_prev_stall = 1'b0;
  int          b_exp_addr = 0, b_reads = 0, b_acc = 0, b_done = 0, b_last_acc = 0;

  task automatic fill_exp(input int sel);
    logic [71:0] d;
    exp_q.delete();
    for (int r = 1; r <= 128; r++)
      for (int c = 1; c <= 128; c++) begin
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            d[(3*wr+wc)*8 +: 8] = pixf(sel, r - 1 + wr, c - 1 + wc);
        exp_q.push_back({8'(r), 8'(c), d});
      end
  endtask

  always @(negedge clk) begin
    logic [87:0] e;
    if (b_prev_stall)
      chk("stall_hold", {1'b1, b_win_row, b_win_col, b_win_data}, {1'b1, b_hold});
    b_prev_stall = b_win_valid && !b_ready;
    b_hold = {b_win_row, b_win_col, b_win_data};
    if (b_rd_en) begin
      chk("big_rd_addr", b_rd_addr, b_exp_addr);
      b_exp_addr++;
      b_reads++;
    end
    if (b_win_valid && b_ready) begin
      chk("big_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("big_window", {b_win_row, b_win_col, b_win_data}, e);
      end
      if (b_full && b_win_col != 8'd1 && b_last_acc != 0)
        chk("back_to_back", cyc - b_last_acc, 1);
      b_last_acc = cyc;
      b_acc++;
    end
    if (b_frame_done) b_done++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    b_ready = b_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // ---------------- 4x4 and 5x3 instances ----------------
  logic        s_start = 1'b0;
  logic        a_rd_en, a_win_valid, a_busy, a_frame_done;
  logic        c_rd_en, c_win_valid, c_busy, c_frame_done;
  logic [14:0] a_rd_addr, c_rd_addr;
  logic [7:0]  a_rd_data = '0, c_rd_data = '0, a_win_row, a_win_col, c_win_row, c_win_col;
  logic [71:0] a_win_data, c_win_data;

  window_stream_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_a (
    .clk(clk), .reset(reset), .start(s_start), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .win_data(a_win_data), .win_valid(a_win_valid),
    .win_ready(1'b1), .win_row(a_win_row), .win_col(a_win_col), .busy(a_busy),
    .frame_done(a_frame_done));

  window_stream_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) u_c (
    .clk(clk), .reset(reset), .start(s_start), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
    .rd_data(c_rd_data), .win_data(c_win_data), .win_valid(c_win_valid),
    .win_ready(1'b1), .win_row(c_win_row), .win_col(c_win_col), .busy(c_busy),
    .frame_done(c_frame_done));

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= 8'(4 * (int'(a_rd_addr) / 4) + int'(a_rd_addr) % 4);
    if (c_rd_en) c_rd_data <= 8'(10 * (int'(c_rd_addr) / 5) + int'(c_rd_addr) % 5);
  end

  logic [87:0] a_log[8], c_log[8];
  int a_n = 0, c_n = 0, a_done = 0, c_done = 0, a_exp_addr = 0, c_exp_addr = 0;
  int a_rd10 = 0, a_first = 0;

  always @(negedge clk) begin
    if (a_rd_en) begin
      chk("a_rd_addr", a_rd_addr, a_exp_addr);
      if (a_rd_addr == 15'd10) a_rd10 = cyc;
      a_exp_addr++;
    end
    if (a_win_valid) begin
      if (a_n == 0) a_first = cyc;
      if (a_n < 8) a_log[a_n] = {a_win_row, a_win_col, a_win_data};
      a_n++;
    end
    if (a_frame_done) a_done++;
    if (c_rd_en) begin
      chk("c_rd_addr", c_rd_addr, c_exp_addr);
      c_exp_addr++;
    end
    if (c_win_valid) begin
      if (c_n < 8) c_log[c_n] = {c_win_row, c_win_col, c_win_data};
      c_n++;
    end
    if (c_frame_done) c_done++;
  end

  // ---------------- directed sequence ----------------
  task automatic pulse(input int which);
    @(posedge clk);
    #1;
    if (which == 0) b_start = 1'b1; else if (which == 1) s_start = 1'b1;
    else begin b_start = 1'b1; s_start = 1'b1; end
    @(posedge clk);
    #1;
    b_start = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int i;
    i = 0;
    while (b_done == 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk(name, i < budget, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic new_frame(input int sel);
    b_sel = sel;
    fill_exp(sel);
    b_exp_addr = 0;
    b_reads = 0;
    b_acc = 0;
    b_done = 0;
    b_last_acc = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", b_rd_en, 0);
    chk("rst_rd_addr", b_rd_addr, 0);
    chk("rst_win_data", b_win_data, 0);
    chk("rst_win_valid", b_win_valid, 0);
    chk("rst_win_row", b_win_row, 0);
    chk("rst_win_col", b_win_col, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_frame_done", b_frame_done, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Frame 1: full speed, plus a start pulse mid-frame that must be ignored.
    new_frame(0);
    chk("model_first", exp_q[0], pk9(1, 1, 0, 1, 2, 1, 2, 3, 2, 3, 4));
    chk("model_last", exp_q[$], pk9(128, 128, 254, 255, 0, 255, 0, 1, 0, 1, 2));
    b_full = 1'b1;
    pulse(2);
    repeat (3000) @(posedge clk);
    @(negedge clk);
    chk("busy_in_run", b_busy, 1);
    pulse(0);
    wait_done(20000, "frame1_timeout");
    chk("f1_windows", b_acc, 16384);
    chk("f1_done_once", b_done, 1);
    chk("f1_reads", b_reads, 16900);
    chk("f1_q_empty", exp_q.size(), 0);
    chk("f1_idle", b_busy, 0);
    b_full = 1'b0;

    // Small frames ran alongside frame 1.
    chk("a_count", a_n, 4);
    chk("a_w0", a_log[0], pk9(1, 1, 0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("a_w1", a_log[1], pk9(1, 2, 1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk("a_w2", a_log[2], pk9(2, 1, 4, 5, 6, 8, 9, 10, 12, 13, 14));
    chk("a_w3", a_log[3], pk9(2, 2, 5, 6, 7, 9, 10, 11, 13, 14, 15));
    chk("a_latency", a_first - a_rd10, 2);
    chk("a_done_once", a_done, 1);
    chk("a_reads", a_exp_addr, 16);
    chk("c_count", c_n, 3);
    chk("c_w0", c_log[0], pk9(1, 1, 0, 1, 2, 10, 11, 12, 20, 21, 22));
    chk("c_w1", c_log[1], pk9(1, 2, 1, 2, 3, 11, 12, 13, 21, 22, 23));
    chk("c_w2", c_log[2], pk9(1, 3, 2, 3, 4, 12, 13, 14, 22, 23, 24));
    chk("c_done_once", c_done, 1);
    chk("c_reads", c_exp_addr, 15);

    // Frame 2: random backpressure.
    new_frame(0);
    b_rand = 1'b1;
    pulse(0);
    wait_done(45000, "frame2_timeout");
    b_rand = 1'b0;
    chk("f2_windows", b_acc, 16384);
    chk("f2_done_once", b_done, 1);
    chk("f2_reads", b_reads, 16900);

    // Frame 3: aborted by reset at window 500.
    new_frame(1);
    pulse(0);
    for (int i = 0; i < 5000 && b_acc < 500; i++) @(posedge clk);
    chk("f3_reached_500", b_acc >= 500, 1);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rd_en", b_rd_en, 0);
    chk("abort_rd_addr", b_rd_addr, 0);
    chk("abort_win_data", b_win_data, 0);
    chk("abort_win_valid", b_win_valid, 0);
    chk("abort_win_row", b_win_row, 0);
    chk("abort_win_col", b_win_col, 0);
    chk("abort_busy", b_busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", b_done, 0);
    chk("abort_stays_idle", b_busy, 0);

    // Frame 4: different image after the abort, so leftover line data would show.
    new_frame(0);
    pulse(0);
    wait_done(20000, "frame4_timeout");
    chk("f4_windows", b_acc, 16384);
    chk("f4_done_once", b_done, 1);
    chk("f4_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
